// File: rtl/usb_fifo_arbiter.sv
// FX2 slave-FIFO master for synchronous mode: round-robin read/write bursts with bus turnaround.
// Define USB_PKTEND_EN to add the PKTEND short-packet commit after an idle timeout.
module usb_fifo_arbiter #(
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned BURST_MAX      = 256,
  parameter logic [1:0]  EP_OUT_ADR     = 2'b00,
  parameter logic [1:0]  EP_IN_ADR      = 2'b10,
  parameter int unsigned PKT_WORDS      = 256,
  parameter int unsigned PKTEND_TIMEOUT = 64
) (
  input  logic              CLKOUT,
  input  logic              rst,
  input  logic              FLAGA,
  input  logic              FLAGD,
  output logic              SLRD,
  output logic              SLWR,
  output logic              SLOE,
`ifdef USB_PKTEND_EN
  output logic              PKTEND,
`endif
  output logic              IFCLK,
  output logic [1:0]        FIFOADR,
  inout  wire  [DATA_W-1:0] FD,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy
);

  localparam int unsigned     CntW     = $clog2(BURST_MAX) + 1;
  localparam logic [CntW-1:0] BurstMax = CntW'(BURST_MAX);

  typedef enum logic [2:0] {
    StIdle,
    StSelRd,
    StRdData,
    StSelWr,
    StWrData
`ifdef USB_PKTEND_EN
    , StPktend
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              last_wr_q, last_wr_d;
  logic [1:0]        fifoadr_q, fifoadr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic rd_req, wr_req, rd_stb, wr_stb, fd_oe;

  assign rd_req = FLAGA & rx_ready;
  assign wr_req = FLAGD & tx_valid;
  assign rd_stb = (state_q == StRdData) && rd_req && (count_q < BurstMax);
  assign wr_stb = (state_q == StWrData) && wr_req && (count_q < BurstMax);

`ifdef USB_PKTEND_EN
  localparam int unsigned     PktW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam int unsigned     IdleW  = $clog2(PKTEND_TIMEOUT + 1);
  localparam logic [PktW-1:0]  PktLast = PktW'(PKT_WORDS - 1);
  localparam logic [IdleW-1:0] IdleTo  = IdleW'(PKTEND_TIMEOUT);

  logic [PktW-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             pkt_timeout;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (state_q == StPktend) begin
      pkt_cnt_d = '0;
    end else if (wr_stb) begin
      pkt_cnt_d = (pkt_cnt_q == PktLast) ? '0 : pkt_cnt_q + 1'b1;
    end
    // Idle counter saturates at the timeout; any activity or pending tx data restarts it.
    idle_cnt_d = '0;
    if (state_q == StIdle && !tx_valid) begin
      idle_cnt_d = (idle_cnt_q == IdleTo) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
    pkt_timeout = (state_q == StIdle) && !tx_valid && (idle_cnt_d == IdleTo) &&
                  (pkt_cnt_q != '0);
  end

  always_ff @(posedge CLKOUT or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign PKTEND = (state_q != StPktend);
`else
  logic unused_pktend_cfg;
  assign unused_pktend_cfg = (PKT_WORDS != 0) ^ (PKTEND_TIMEOUT != 0);
`endif

  // State register
  always_ff @(posedge CLKOUT or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_req && wr_req) begin
          state_d = last_wr_q ? StSelRd : StSelWr;
        end else if (rd_req) begin
          state_d = StSelRd;
        end else if (wr_req) begin
          state_d = StSelWr;
`ifdef USB_PKTEND_EN
        end else if (pkt_timeout) begin
          state_d = StPktend;
`endif
        end
      end
      StSelRd:  state_d = StRdData;
      StRdData: if (!rd_req || count_q == BurstMax) state_d = StIdle;
      StSelWr:  state_d = StWrData;
      StWrData: if (!wr_req || count_q == BurstMax) state_d = StIdle;
`ifdef USB_PKTEND_EN
      StPktend: state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

  // Burst counter, grant history, endpoint select and receive capture
  always_comb begin
    count_d    = count_q;
    last_wr_d  = last_wr_q;
    fifoadr_d  = fifoadr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rd_stb;
    if (state_q == StSelRd || state_q == StSelWr) begin
      count_d = '0;
    end else if (rd_stb || wr_stb) begin
      count_d = count_q + 1'b1;
    end
    if (state_q == StSelRd) last_wr_d = 1'b0;
    if (state_q == StSelWr) last_wr_d = 1'b1;
    // Address follows the next state so it is already valid during the SEL cycle.
    if (state_d == StSelRd) begin
      fifoadr_d = EP_OUT_ADR;
    end else if (state_d == StSelWr) begin
      fifoadr_d = EP_IN_ADR;
`ifdef USB_PKTEND_EN
    end else if (state_d == StPktend) begin
      fifoadr_d = EP_IN_ADR;
`endif
    end
    if (rd_stb) rx_data_d = FD;
  end

  always_ff @(posedge CLKOUT or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      last_wr_q  <= 1'b1;
      fifoadr_q  <= EP_OUT_ADR;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      last_wr_q  <= last_wr_d;
      fifoadr_q  <= fifoadr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Outputs: decoded from the registered state so reset releases the bus asynchronously.
  always_comb begin
    SLRD     = ~rd_stb;
    SLWR     = ~wr_stb;
    tx_ready = wr_stb;
    SLOE     = ~((state_q == StSelRd) || (state_q == StRdData));
    fd_oe    = (state_q == StSelWr) || (state_q == StWrData);
    busy     = (state_q != StIdle);
  end

  assign FD       = fd_oe ? tx_data : {DATA_W{1'bz}};
  assign IFCLK    = ~CLKOUT;
  assign FIFOADR  = fifoadr_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Directed bench for usb_fifo_arbiter with a small FX2 FIFO model and data scoreboards.
module tb_usb_fifo_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned BM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flaga = 1'b0;
  logic          flagd;
  logic          slrd, slwr, sloe, ifclk, rx_valid, tx_ready, busy;
  logic          rx_ready;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] fx2_word = '0;
  logic [DW-1:0] rx_data;
  logic [1:0]    fifoadr;
  wire  [DW-1:0] fd;
`ifdef USB_PKTEND_EN
  logic          pktend;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] out_q[$], tx_q[$], exp_rx[$], exp_wr[$];
  int            bk[$], bl[$];
  int            cyc = 0, rd_total = 0, wr_total = 0, rd_run = 0, wr_run = 0;
  int            first_rd_cyc = -1, first_busy_cyc = -1, fall_cyc = -1;
  int            pkt_low = 0, pkt_first_cyc = -1;
  logic [1:0]    pkt_adr = '0;
  logic          rd_stb_s = 1'b0, wr_stb_s = 1'b0;

  always #5 clk = ~clk;

  // FX2 drives FD only while SLOE is asserted.
  assign fd = !sloe ? fx2_word : {DW{1'bz}};

  usb_fifo_arbiter #(
    .DATA_W(DW), .BURST_MAX(BM), .EP_OUT_ADR(2'b00), .EP_IN_ADR(2'b10),
    .PKT_WORDS(256), .PKTEND_TIMEOUT(8)
  ) dut (
    .CLKOUT(clk), .rst(rst), .FLAGA(flaga), .FLAGD(flagd), .SLRD(slrd), .SLWR(slwr),
    .SLOE(sloe),
`ifdef USB_PKTEND_EN
    .PKTEND(pktend),
`endif
    .IFCLK(ifclk), .FIFOADR(fifoadr), .FD(fd), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [DW-1:0] w);
    tx_q.push_back(w);
    exp_wr.push_back(w);
  endtask

  task automatic push_out(input logic [DW-1:0] w);
    out_q.push_back(w);
    exp_rx.push_back(w);
  endtask

  task automatic clear_logs();
    bk.delete();
    bl.delete();
    rd_total = 0;
    wr_total = 0;
    first_rd_cyc = -1;
    first_busy_cyc = -1;
  endtask

  task automatic wait_quiet(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(out_q.size() == 0 && tx_q.size() == 0 && !busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 400), 1);
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic check_bursts(input string tag, input int kinds[$], input int lens[$]);
    check({tag, "_nbursts"}, bl.size(), lens.size());
    for (int i = 0; i < lens.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), (i < bk.size()) ? bk[i] : -1, kinds[i]);
      check($sformatf("%s_len%0d", tag, i), (i < bl.size()) ? bl[i] : -1, lens[i]);
    end
  endtask

  // Monitor: samples strobes and outputs on the falling edge, scoreboards data.
  initial forever begin
    logic [31:0] exp;
    @(negedge clk);
    cyc++;
    rd_stb_s = !slrd;
    wr_stb_s = !slwr;
    if (rx_valid) begin
      exp = (exp_rx.size() != 0) ? 32'(exp_rx.pop_front()) : 32'hFFFF_FFFF;
      check("rx_data", 32'(rx_data), exp);
    end
    if (!slwr) begin
      exp = (exp_wr.size() != 0) ? 32'(exp_wr.pop_front()) : 32'hFFFF_FFFF;
      check("wr_data", 32'(fd), exp);
      check("tx_ready_on_wr", 32'(tx_ready), 1);
      wr_total++;
      wr_run++;
    end
    if (!slrd) begin
      rd_total++;
      rd_run++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (!sloe) begin
      check("no_wr_while_oe", 32'(slwr), 1);
      if (out_q.size() != 0) check("fd_owned_by_fx2", 32'(fd), 32'(fx2_word));
    end
    if (busy && first_busy_cyc < 0) first_busy_cyc = cyc;
    if (!busy) begin
      if (rd_run > 0) begin bk.push_back(0); bl.push_back(rd_run); rd_run = 0; end
      if (wr_run > 0) begin
        bk.push_back(1); bl.push_back(wr_run); wr_run = 0; fall_cyc = cyc;
      end
    end
`ifdef USB_PKTEND_EN
    if (!pktend) begin
      pkt_low++;
      if (pkt_first_cyc < 0) begin pkt_first_cyc = cyc; pkt_adr = fifoadr; end
    end
`endif
  end

  // FX2 FIFO and tx source model: consume strobed words just after the rising edge.
  initial forever begin
    logic [DW-1:0] tmp;
    @(posedge clk);
    #1;
    if (rd_stb_s && out_q.size() != 0) tmp = out_q.pop_front();
    if (wr_stb_s && tx_q.size() != 0) tmp = tx_q.pop_front();
    flaga    = (out_q.size() != 0);
    fx2_word = flaga ? out_q[0] : '0;
    tx_valid = (tx_q.size() != 0);
    tx_data  = tx_valid ? tx_q[0] : '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    flagd = 1'b0;
    rx_ready = 1'b0;
    #3;
    check("rst_slrd", 32'(slrd), 1);
    check("rst_slwr", 32'(slwr), 1);
    check("rst_sloe", 32'(sloe), 1);
    check("rst_fifoadr", 32'(fifoadr), 32'(2'b00));
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_tx_ready", 32'(tx_ready), 0);
    check("rst_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Reset asserted in the middle of a write burst
    @(posedge clk); #1;
    clear_logs();
    for (int i = 1; i <= 6; i++) push_tx(16'(16'h1000 + i));
    flagd = 1'b1;
    n = 0;
    while (wr_total < 2 && n < 100) begin @(posedge clk); n++; end
    check("rst_mid_reached", 32'(wr_total >= 2), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_slwr", 32'(slwr), 1);
    check("rst_mid_sloe", 32'(sloe), 1);
    check("rst_mid_tx_ready", 32'(tx_ready), 0);
    check("rst_mid_busy", 32'(busy), 0);
    @(negedge clk); #1 rst = 1'b0;
    #1;
    check("rst_rel_busy", 32'(busy), 0);
    check("rst_rel_fifoadr", 32'(fifoadr), 32'(2'b00));
    wait_quiet("rst_resume");
    check("rst_words", wr_total, 6);
    check("rst_sb_empty", exp_wr.size(), 0);

    // Read burst of five words; BURST_MAX=4 splits it 4+1
    clear_logs();
    rx_ready = 1'b1;
    for (int i = 1; i <= 5; i++) push_out(16'(i));
    wait_quiet("rd");
    check("rd_strobes", rd_total, 5);
    check("rd_sb_empty", exp_rx.size(), 0);
    check("rd_sel_lead", first_rd_cyc - first_busy_cyc, 1);
    check_bursts("rd", '{0, 0}, '{4, 1});

    // Write burst limit: ten words -> 4, 4, 2
    clear_logs();
    for (int i = 0; i < 10; i++) push_tx(16'(16'h2000 + i));
    wait_quiet("blim");
    check("blim_words", wr_total, 10);
    check("blim_sb_empty", exp_wr.size(), 0);
    check_bursts("blim", '{1, 1, 1}, '{4, 4, 2});

    // Arbitration with both sides requesting: RD, WR, RD, WR
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      push_out(16'(16'h3000 + i));
      push_tx(16'(16'h4000 + i));
    end
    wait_quiet("arb");
    check("arb_rd", rd_total, 8);
    check("arb_wr", wr_total, 8);
    check_bursts("arb", '{0, 1, 0, 1}, '{4, 4, 4, 4});

    // FLAGD drops after word 3 of 6
    clear_logs();
    for (int i = 1; i <= 6; i++) push_tx(16'(16'h5000 + i));
    n = 0;
    while (wr_total < 3 && n < 100) begin @(posedge clk); n++; end
    check("stall_reached", 32'(wr_total >= 3), 1);
    #1 flagd = 1'b0;
    @(negedge clk);
    check("stall_slwr", 32'(slwr), 1);
    check("stall_tx_ready", 32'(tx_ready), 0);
    repeat (2) @(posedge clk);
    #1 flagd = 1'b1;
    wait_quiet("stall");
    check("stall_words", wr_total, 6);
    check("stall_sb_empty", exp_wr.size(), 0);
    check_bursts("stall", '{1, 1}, '{3, 3});

`ifdef USB_PKTEND_EN
    // Short packet commit after the idle timeout
    clear_logs();
    pkt_low = 0;
    pkt_first_cyc = -1;
    for (int i = 1; i <= 3; i++) push_tx(16'(16'h6000 + i));
    wait_quiet("pkt");
    check("pkt_low_cycles", pkt_low, 1);
    check("pkt_delay", pkt_first_cyc - fall_cyc, 8);
    check("pkt_fifoadr", 32'(pkt_adr), 32'(2'b10));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
